// File: rtl/arm_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arm_cpu_pkg
// Brief   : Shared register-bank constants and the writeback entry type.
// Revision: 1.0 - initial release
// ============================================================================
package arm_cpu_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int ZERO_REG   = 31;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_fifo
// Brief   : Synchronous FIFO of writeback entries; power-of-two depth.
// Revision: 1.0 - initial release
// ============================================================================
module wb_fifo
    import arm_cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  wb_entry_t              i_data,
    output wb_entry_t              o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int                  c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]    c_CNT_ONE   = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]    c_CNT_DEPTH = (c_PTR_W + 1)'(DEPTH);

    wb_entry_t            r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full    = (r_count == c_CNT_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/register_writeback.sv
`default_nettype none
// ============================================================================
// Module  : register_writeback
// Brief   : Register-bank writer: load/ALU arbitration, output registers and
//           pending-write scoreboard for decode hazard stalls.
// Revision: 1.0 - initial release
// ============================================================================
module register_writeback
    import arm_cpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_address,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_address,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic [ADDR_WIDTH-1:0] query_address_1,
    input  logic [ADDR_WIDTH-1:0] query_address_2,
    output logic                  query_busy_1,
    output logic                  query_busy_2,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0] write_data
);

    localparam int                    c_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int                    c_NREG  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_ZERO  = ADDR_WIDTH'(ZERO_REG);

    wb_entry_t              w_head;
    wb_entry_t              w_alu_entry;
    wb_entry_t              w_sel;
    logic                   w_sel_valid;
    logic                   w_alu_accept;
    logic                   w_push;
    logic                   w_pop;
    logic [c_CNT_W-1:0]     w_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_sel_writes;
    logic [c_NREG-1:0]      w_set;
    logic [c_NREG-1:0]      w_clr;

    logic                   r_write;
    logic [ADDR_WIDTH-1:0]  r_write_address;
    logic [DATA_WIDTH-1:0]  r_write_data;
    logic [c_NREG-1:0]      r_busy;

    // Ready comes from the registered count only, so it never waits on a pop.
    assign alu_ready    = !w_full;
    assign w_alu_accept = alu_valid && alu_ready;
    assign w_alu_entry  = '{address: alu_address, data: alu_data};

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_alu_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Loads win; then the oldest buffered ALU result; then a same-cycle bypass.
    always_comb begin
        w_sel       = '0;
        w_sel_valid = 1'b0;
        w_pop       = 1'b0;
        w_push      = w_alu_accept;
        if (mem_valid) begin
            w_sel       = '{address: mem_address, data: mem_data};
            w_sel_valid = 1'b1;
        end else if (!w_empty) begin
            w_sel       = w_head;
            w_sel_valid = 1'b1;
            w_pop       = 1'b1;
        end else if (w_alu_accept) begin
            w_sel       = w_alu_entry;
            w_sel_valid = 1'b1;
            w_push      = 1'b0;
        end
    end

    assign w_sel_writes = w_sel_valid && (w_sel.address != c_ZERO);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_write         <= 1'b0;
            r_write_address <= '0;
            r_write_data    <= '0;
        end else begin
            r_write <= w_sel_writes;
            if (w_sel_writes) begin
                r_write_address <= w_sel.address;
                r_write_data    <= w_sel.data;
            end
        end
    end

    // Set overrides clear so a re-issue in the clearing cycle stays pending.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue_valid && (issue_address != c_ZERO)) begin
            w_set[issue_address] = 1'b1;
        end
        if (r_write) begin
            w_clr[r_write_address] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign query_busy_1  = r_busy[query_address_1] && (query_address_1 != c_ZERO);
    assign query_busy_2  = r_busy[query_address_2] && (query_address_2 != c_ZERO);
    assign write         = r_write;
    assign write_address = r_write_address;
    assign write_data    = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_register_writeback.sv
`default_nettype none
// ============================================================================
// Module  : tb_register_writeback
// Brief   : Self-checking bench for register_writeback against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_register_writeback;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_address = '0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_address = '0;
    logic [63:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic [4:0]  mem_address = '0;
    logic [63:0] mem_data = '0;
    logic [4:0]  query_address_1 = '0;
    logic [4:0]  query_address_2 = '0;
    logic        query_busy_1;
    logic        query_busy_2;
    logic        write;
    logic [4:0]  write_address;
    logic [63:0] write_data;

    register_writeback #(.FIFO_DEPTH(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_address   (issue_address),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_address     (alu_address),
        .alu_data        (alu_data),
        .mem_valid       (mem_valid),
        .mem_address     (mem_address),
        .mem_data        (mem_data),
        .query_address_1 (query_address_1),
        .query_address_2 (query_address_2),
        .query_busy_1    (query_busy_1),
        .query_busy_2    (query_busy_2),
        .write           (write),
        .write_address   (write_address),
        .write_data      (write_data)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic [4:0]  ia;
        logic        av;
        logic [4:0]  aa;
        logic [63:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [63:0] md;
        logic [4:0]  q1;
        logic [4:0]  q2;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        ew;
        logic [4:0]  ea;
        logic [63:0] ed;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: pending ALU results in acceptance order, pending-write set,
    // and the writer outputs expected after the next edge.
    logic [68:0] mq [$];
    logic [68:0] obs [$];
    bit   [31:0] m_busy = '0;
    bit          m_known = 1'b0;
    logic        m_w = 1'b0;
    logic [4:0]  m_wa = '0;
    logic [63:0] m_wd = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(bit rst, bit iv, int ia, bit av, int aa, logic [63:0] ad,
                                 bit mv, int ma, logic [63:0] md, int q1, int q2);
        stim_t s;
        s.rst = rst; s.iv = iv; s.ia = 5'(ia);
        s.av  = av;  s.aa = 5'(aa); s.ad = ad;
        s.mv  = mv;  s.ma = 5'(ma); s.md = md;
        s.q1  = 5'(q1); s.q2 = 5'(q2);
        return s;
    endfunction

    task automatic cycle(input stim_t s, output bit accepted);
        logic [68:0] sel;
        bit          sel_v;
        bit          acc;
        bit          rdy;
        @(negedge clock);
        reset = s.rst;   issue_valid = s.iv; issue_address = s.ia;
        alu_valid = s.av; alu_address = s.aa; alu_data = s.ad;
        mem_valid = s.mv; mem_address = s.ma; mem_data = s.md;
        query_address_1 = s.q1; query_address_2 = s.q2;
        #1;
        rdy = (mq.size() < 4);
        if (m_known) begin
            chk("alu_ready", alu_ready, rdy);
            chk("busy_1", query_busy_1, m_busy[s.q1] && (s.q1 != 5'd31));
            chk("busy_2", query_busy_2, m_busy[s.q2] && (s.q2 != 5'd31));
        end
        acc = s.av && rdy;
        accepted = acc && !s.rst;
        if (s.rst) begin
            mq.delete();
            m_busy = '0;
            m_w = 1'b0; m_wa = '0; m_wd = '0;
            m_known = 1'b1;
        end else begin
            sel_v = 1'b1;
            sel   = '0;
            if (s.mv) sel = {s.ma, s.md};
            else if (mq.size() != 0) sel = mq.pop_front();
            else if (acc) begin sel = {s.aa, s.ad}; acc = 1'b0; end
            else sel_v = 1'b0;
            if (acc) mq.push_back({s.aa, s.ad});
            if (m_w) m_busy[m_wa] = 1'b0;
            if (s.iv && s.ia != 5'd31) m_busy[s.ia] = 1'b1;
            m_w = sel_v && (sel[68:64] != 5'd31);
            if (m_w) begin m_wa = sel[68:64]; m_wd = sel[63:0]; end
        end
        @(posedge clock);
        #1;
        if (m_known) begin
            chk("write", write, m_w);
            chk("write_address", write_address, m_wa);
            chk("write_data", write_data, m_wd);
        end
        if (write === 1'b1) obs.push_back({write_address, write_data});
    endtask

    vec_t vecs [8];
    bit   acc;
    int   idx;
    int   n;
    stim_t rs;

    initial begin
        // Reset with every valid high, then a lone ALU result, then load-vs-ALU priority.
        vecs[0] = '{s: mk(1,1,3,1,2,64'h11,1,6,64'h22,3,2), ew: 1'b0, ea: 5'd0, ed: 64'h0};
        vecs[1] = '{s: mk(1,1,3,1,2,64'h11,1,6,64'h22,3,2), ew: 1'b0, ea: 5'd0, ed: 64'h0};
        vecs[2] = '{s: mk(0,0,0,0,0,64'h0,0,0,64'h0,3,2),    ew: 1'b0, ea: 5'd0, ed: 64'h0};
        vecs[3] = '{s: mk(0,0,0,1,5,64'h1234,0,0,64'h0,5,0), ew: 1'b1, ea: 5'd5, ed: 64'h1234};
        vecs[4] = '{s: mk(0,0,0,0,0,64'h0,0,0,64'h0,5,0),    ew: 1'b0, ea: 5'd5, ed: 64'h1234};
        vecs[5] = '{s: mk(0,0,0,1,4,64'hBBBB,1,3,64'hAAAA,3,4), ew: 1'b1, ea: 5'd3, ed: 64'hAAAA};
        vecs[6] = '{s: mk(0,0,0,0,0,64'h0,0,0,64'h0,3,4),    ew: 1'b1, ea: 5'd4, ed: 64'hBBBB};
        vecs[7] = '{s: mk(0,0,0,0,0,64'h0,0,0,64'h0,3,4),    ew: 1'b0, ea: 5'd4, ed: 64'hBBBB};

        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].s, acc);
            chk("vec_write", write, vecs[i].ew);
            chk("vec_address", write_address, vecs[i].ea);
            chk("vec_data", write_data, vecs[i].ed);
            if (i == 1) begin
                chk("reset_ready", alu_ready, 1'b1);
                chk("reset_busy", query_busy_1, 1'b0);
            end
        end

        // Loads every cycle while the ALU keeps offering: FIFO fills, then drains in order.
        obs.delete();
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            cycle(mk(0,0,0,1,1+idx,64'hC0+idx,1,10+c,64'hD0+c,0,0), acc);
            if (acc) idx++;
        end
        chk("full_ready", alu_ready, 1'b0);
        chk("full_accepts", idx, 4);
        for (int c = 0; c < 6; c++) cycle(mk(0,0,0,0,0,0,0,0,0,0,0), acc);
        chk("full_written", obs.size(), 10);
        for (int i = 0; i < 4 && i + 6 < obs.size(); i++)
            chk("full_order", obs[6+i], {5'(1+i), 64'(64'hC0 + i)});

        // Scoreboard set/clear timing, including a re-issue during the clearing write.
        cycle(mk(0,1,7,0,0,0,0,0,0,7,0), acc);
        chk("sb_set", query_busy_1, 1'b1);
        cycle(mk(0,0,0,0,0,0,1,7,64'h77,7,0), acc);
        chk("sb_during_write", query_busy_1, 1'b1);
        cycle(mk(0,0,0,0,0,0,0,0,0,7,0), acc);
        chk("sb_cleared", query_busy_1, 1'b0);
        cycle(mk(0,1,7,0,0,0,0,0,0,7,0), acc);
        cycle(mk(0,0,0,0,0,0,1,7,64'h78,7,0), acc);
        cycle(mk(0,1,7,0,0,0,0,0,0,7,0), acc);
        chk("sb_set_wins", query_busy_1, 1'b1);
        cycle(mk(0,0,0,0,0,0,0,0,0,7,0), acc);
        chk("sb_still_set", query_busy_1, 1'b1);
        cycle(mk(0,0,0,0,0,0,1,7,64'h79,7,0), acc);
        cycle(mk(0,0,0,0,0,0,0,0,0,7,0), acc);

        // Results to the zero register are consumed silently.
        n = obs.size();
        cycle(mk(0,1,31,1,31,64'hDEAD,0,0,0,31,31), acc);
        chk("xzr_write", write, 1'b0);
        chk("xzr_busy", query_busy_1, 1'b0);
        cycle(mk(0,0,0,0,0,0,1,31,64'hBEEF,31,31), acc);
        chk("xzr_load_write", write, 1'b0);
        cycle(mk(0,0,0,0,0,0,0,0,0,31,31), acc);
        chk("xzr_none", obs.size(), n);

        // Reset while three ALU results are buffered: none of them may be written.
        for (int c = 0; c < 3; c++) cycle(mk(0,0,0,1,20+c,64'hE0+c,1,25+c,64'hF0+c,0,0), acc);
        cycle(mk(1,0,0,0,0,0,0,0,0,0,0), acc);
        chk("rst_write", write, 1'b0);
        n = obs.size();
        for (int c = 0; c < 5; c++) cycle(mk(0,0,0,0,0,0,0,0,0,0,0), acc);
        chk("rst_discard", obs.size(), n);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rs = mk(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom_range(0, 31),
                    $urandom_range(0, 1), $urandom_range(0, 31), {$urandom, $urandom},
                    ($urandom_range(0, 2) == 0), $urandom_range(0, 31), {$urandom, $urandom},
                    $urandom_range(0, 31), $urandom_range(0, 31));
            cycle(rs, acc);
        end
        for (int c = 0; c < 8; c++) cycle(mk(0,0,0,0,0,0,0,0,0,0,0), acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
